dmem_port_arbiter: RTL



---
 rtl/dmem_port_arbiter_pkg.sv | 19 +
 rtl/dmem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding,
// default sizing constants and the DMA address legality check.
package dmem_port_arbiter_pkg;

  localparam int unsigned DEF_RAM_BYTES    = 1024;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } arb_state_e;

  // DMA may only touch word-aligned addresses inside the RAM window.
  function automatic logic dma_addr_ok(input logic [63:0] addr,
                                       input logic [63:0] ram_bytes);
    return (addr < ram_bytes) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory slave port between the CPU MEM stage (zero-latency,
// default priority) and a req/ack DMA master served in CPU-idle cycles, with
// a starvation counter that steals one CPU cycle via cpu_stall.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RAM_BYTES    = DEF_RAM_BYTES,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic cpu_acc;
  logic dma_ok;
  logic idle_req;
  logic force_slot;
  logic dma_sel;

  // Arbitration decision and slave-port mux; nothing is granted while in reset.
  always_comb begin
    cpu_acc    = cpu_rd | cpu_wr;
    dma_ok     = dma_addr_ok(64'(dma_addr), 64'(RAM_BYTES));
    idle_req   = reset && (state == ST_IDLE) && dma_req;
    force_slot = idle_req && dma_ok && cpu_acc &&
                 (starve_cnt == CNT_W'(STARVE_LIMIT));
    dma_sel    = idle_req && dma_ok && (!cpu_acc || force_slot);

    cpu_stall  = force_slot;
    mem_rd     = cpu_rd;
    mem_wr     = cpu_wr;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    cpu_rdata  = mem_rdata;
    if (dma_sel) begin
      mem_rd    = !dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      cpu_rdata = '0;
    end
  end

  assign dma_ack   = ack_q & reset;
  assign dma_err   = err_q;
  assign dma_rdata = rdata_q;

  // Handshake FSM, registered DMA response and starvation counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma_sel) begin
            state   <= ST_ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= dma_wr ? '0 : mem_rdata;
          end else if (dma_req && !dma_ok) begin
            state   <= ST_ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase

      if (!dma_req || dma_sel) begin
        starve_cnt <= '0;
      end else if ((state == ST_IDLE) && dma_ok && cpu_acc && !force_slot) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule
